// File: rtl/dmx512_tx.sv
// dmx512_tx: DMX512 transmitter with channel buffer and break/MAB/slot serialiser.
// Ports: i_clk/i_rst_n clock and sync active-low reset; i_wr_addr/i_wr_data/i_wr_en channel
// writes (channel k at address k-1); i_channel_count data slots per frame (clamped);
// i_start_code slot-0 byte; i_start frame trigger; i_repeat auto-restart level;
// i_commit bank swap request; o_data line (idle high); o_busy frame in flight;
// o_frame_done one-cycle end-of-frame pulse.
// Define DMX_DOUBLE_BUFFER_EN for front/back banks swapped on commit at the next break.
module dmx512_tx #(
  parameter int MAX_CHANNELS = 512,
  parameter int BIT_CYCLES   = 96,
  parameter int BREAK_CYCLES = 4224,
  parameter int MAB_CYCLES   = 288,
  parameter int IFD_CYCLES   = 0,
  parameter int MTBP_CYCLES  = 960,
  localparam int ADDR_W = $clog2(MAX_CHANNELS),
  localparam int CNT_W  = $clog2(MAX_CHANNELS + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic              i_wr_en,
  input  logic [CNT_W-1:0]  i_channel_count,
  input  logic [7:0]        i_start_code,
  input  logic              i_start,
  input  logic              i_repeat,
  input  logic              i_commit,
  output logic              o_data,
  output logic              o_busy,
  output logic              o_frame_done
);
  localparam int M0 = BREAK_CYCLES > MTBP_CYCLES ? BREAK_CYCLES : MTBP_CYCLES;
  localparam int M1 = M0 > MAB_CYCLES ? M0 : MAB_CYCLES;
  localparam int M2 = M1 > IFD_CYCLES ? M1 : IFD_CYCLES;
  localparam int M3 = M2 > BIT_CYCLES ? M2 : BIT_CYCLES;
  localparam int CW = $clog2(M3 + 1);
`ifdef DMX_DOUBLE_BUFFER_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  typedef enum logic [2:0] {IDLE, BRK, MAB, SLOT, IFD, MTBP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [CNT_W-1:0] slot_q, slot_d, count_q, count_d;
  logic [7:0] sc_q, sc_d, byte_q, byte_d, rd_q;
  logic fin_q, fin_d, data_d, busy_d, done_d;
  logic tick, last, brk, nxt, we, re;
  logic [10:0] frame;
  logic [7:0] mem [0:(NB << ADDR_W) - 1];
  assign tick = cnt_q == '0;
  assign last = slot_q == count_q;
  assign we = i_wr_en && CNT_W'(i_wr_addr) < CNT_W'(MAX_CHANNELS);
  // fetch the byte for the next slot once, at the start of the current slot's first stop bit
  assign re = state_q == SLOT && bit_q == 4'd9 && cnt_q == CW'(BIT_CYCLES - 1) && !last;
`ifdef DMX_DOUBLE_BUFFER_EN
  logic bank_q, pend_q;
  logic [ADDR_W:0] waddr, raddr;
  assign waddr = {~bank_q, i_wr_addr};
  assign raddr = {bank_q, ADDR_W'(slot_q)};
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      bank_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      if (brk && pend_q) bank_q <= ~bank_q;
      pend_q <= i_commit | (pend_q & ~brk);
    end
`else
  logic [ADDR_W-1:0] waddr, raddr;
  logic unused_commit;
  assign waddr = i_wr_addr;
  assign raddr = ADDR_W'(slot_q);
  assign unused_commit = i_commit;
`endif
  // read-before-write: a fetch colliding with a write returns the old byte
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= i_wr_data;
    if (re) rd_q <= mem[raddr];
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      slot_q       <= '0;
      count_q      <= '0;
      sc_q         <= '0;
      byte_q       <= '0;
      fin_q        <= 1'b0;
      o_data       <= 1'b1;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      slot_q       <= slot_d;
      count_q      <= count_d;
      sc_q         <= sc_d;
      byte_q       <= byte_d;
      fin_q        <= fin_d;
      o_data       <= data_d;
      o_busy       <= busy_d;
      o_frame_done <= done_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
    bit_d   = bit_q;
    slot_d  = slot_q;
    count_d = count_q;
    sc_d    = sc_q;
    byte_d  = byte_q;
    fin_d   = 1'b0;
    brk     = 1'b0;
    nxt     = 1'b0;
    case (state_q)
      IDLE: brk = i_start;
      BRK: if (tick) begin
        state_d = MAB;
        cnt_d   = CW'(MAB_CYCLES - 1);
      end
      MAB: nxt = tick;
      SLOT: if (tick) begin
        if (bit_q != 4'd10) begin
          bit_d = bit_q + 1'b1;
          cnt_d = CW'(BIT_CYCLES - 1);
        end else if (!last) begin
          slot_d = slot_q + 1'b1;
          if (IFD_CYCLES == 0) nxt = 1'b1;
          else begin
            state_d = IFD;
            cnt_d   = CW'(IFD_CYCLES - 1);
          end
        end else begin
          fin_d   = 1'b1;
          state_d = i_repeat ? MTBP : IDLE;
          cnt_d   = i_repeat ? CW'(MTBP_CYCLES - 1) : '0;
        end
      end
      IFD: nxt = tick;
      MTBP: brk = tick;
      default: state_d = IDLE;
    endcase
    if (nxt) begin
      state_d = SLOT;
      cnt_d   = CW'(BIT_CYCLES - 1);
      bit_d   = '0;
      byte_d  = state_q == MAB ? sc_q : rd_q;
    end
    if (brk) begin
      state_d = BRK;
      cnt_d   = CW'(BREAK_CYCLES - 1);
      slot_d  = '0;
      sc_d    = i_start_code;
      count_d = i_channel_count > CNT_W'(MAX_CHANNELS) ? CNT_W'(MAX_CHANNELS) : i_channel_count;
    end
  end
  // slot shifts out LSB first: start bit, 8 data bits, two stop bits
  assign frame = {2'b11, byte_q, 1'b0};
  always_comb begin
    data_d = state_q == BRK ? 1'b0 : state_q == SLOT ? frame[bit_q] : 1'b1;
    busy_d = state_q == BRK || state_q == MAB || state_q == SLOT || state_q == IFD;
    done_d = fin_q;
  end
endmodule

// File: tb/tb_dmx512_tx.sv
// tb_dmx512_tx: directed self-checking bench for dmx512_tx (six-channel buffer, default timing)
module tb_dmx512_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic wr_en = 1'b0;
  logic [2:0] channel_count = '0;
  logic [7:0] start_code = '0;
  logic start = 1'b0;
  logic rpt = 1'b0;
  logic commit = 1'b0;
  logic data, busy, frame_done;
  int checks = 0;
  int errs = 0;
  int cyc = 0;
  logic [7:0] mdl [0:5];
  int ns, f, d, f2, d2, k, seen;
  dmx512_tx #(.MAX_CHANNELS(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_en(wr_en),
    .i_channel_count(channel_count), .i_start_code(start_code), .i_start(start),
    .i_repeat(rpt), .i_commit(commit), .o_data(data), .o_busy(busy), .o_frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] v);
    wr_addr = a;
    wr_data = v;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic load();
    for (int a = 0; a < 6; a++) wr(3'(a), mdl[a]);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask
  task automatic pulse_start(output int t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = cyc;
  endtask
  task automatic frame(input int n, input logic [7:0] sc, output int fs, output int de);
    int len;
    logic [10:0] w;
    logic [7:0] b;
    fs = -1;
    de = -1;
    len = 0;
    while (data !== 1'b0 && len < 12000) begin @(negedge clk); len++; end
    if (data !== 1'b0) begin
      check("break_fall", 0, 1);
      return;
    end
    fs = cyc;
    check("busy_hi", busy, 1);
    len = 0;
    while (data === 1'b0 && len < 5000) begin @(negedge clk); len++; end
    check("break_len", len, 4224);
    len = 0;
    while (data === 1'b1 && len < 1000) begin @(negedge clk); len++; end
    check("mab_len", len, 288);
    repeat (48) @(negedge clk);
    for (int s = 0; s <= n; s++) begin
      b = s == 0 ? sc : mdl[s-1];
      for (int i = 0; i < 11; i++) begin
        if (s != 0 || i != 0) repeat (96) @(negedge clk);
        w[i] = data;
      end
      check($sformatf("slot%0d", s), w, {2'b11, b, 1'b0});
    end
    len = 0;
    while (frame_done !== 1'b1 && len < 200) begin @(negedge clk); len++; end
    de = cyc;
    check("done_at", de - fs, 4512 + (n + 1) * 1056);
    check("busy_lo", busy, 0);
    @(negedge clk);
    check("done_pulse", frame_done, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data", data, 1);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mdl[0] = 8'hA5; mdl[1] = 8'h3C; mdl[2] = 8'h00; mdl[3] = 8'h00; mdl[4] = 8'h00; mdl[5] = 8'h00;
    load();
    channel_count = 3'd2;
    start_code = 8'h00;
    pulse_start(ns);
    check("idle_before_edge", data, 1);
    frame(2, 8'h00, f, d);
    check("start_lat", f - ns, 1);
    mdl[0] = 8'h01; mdl[1] = 8'h80; mdl[2] = 8'hFF; mdl[3] = 8'h00; mdl[4] = 8'h69; mdl[5] = 8'h96;
    load();
    channel_count = 3'd0;
    start_code = 8'h55;
    pulse_start(ns);
    frame(0, 8'h55, f, d);
    channel_count = 3'd7;
    start_code = 8'hAA;
    pulse_start(ns);
    frame(6, 8'hAA, f, d);
    mdl[0] = 8'h81;
    load();
    channel_count = 3'd1;
    start_code = 8'hCC;
    rpt = 1'b1;
    pulse_start(ns);
    frame(1, 8'hCC, f, d);
    fork
      frame(1, 8'hCC, f2, d2);
      begin
        for (int j = 0; j < 3000 && !busy; j++) @(negedge clk);
        repeat (1000) @(negedge clk);
        rpt = 1'b0;
        start_code = 8'h00;
        wr(3'd0, 8'h77);
`ifndef DMX_DOUBLE_BUFFER_EN
        mdl[0] = 8'h77;
`endif
        pulse_start(k);
      end
    join
    check("mtbp_gap", f2 - d, 960);
    seen = 0;
    for (int j = 0; j < 1500; j++) begin
      @(negedge clk);
      if (busy || !data) seen = 1;
    end
    check("idle_after", seen, 0);
    mdl[0] = 8'h5A; mdl[1] = 8'h3C;
    load();
    channel_count = 3'd2;
    start_code = 8'h00;
    pulse_start(ns);
    k = 0;
    while (data !== 1'b0 && k < 100) begin @(negedge clk); k++; end
    repeat (4512 + 1056 + 288 + 40) @(negedge clk);
    check("pre_rst_bit", data, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_data", data, 1);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", data, 1);
    load();
    pulse_start(ns);
    frame(2, 8'h00, f, d);
    check("restart_lat", f - ns, 1);
    mdl[0] = 8'h11;
    load();
    channel_count = 3'd1;
    start_code = 8'h00;
    pulse_start(ns);
    fork
      frame(1, 8'h00, f, d);
      begin
        for (int j = 0; j < 100 && !busy; j++) @(negedge clk);
        repeat (100) @(negedge clk);
        wr(3'd0, 8'h22);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
`ifndef DMX_DOUBLE_BUFFER_EN
        mdl[0] = 8'h22;
`endif
      end
    join
    mdl[0] = 8'h22;
    pulse_start(ns);
    frame(1, 8'h00, f, d);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
